// File: rtl/cell_writer.sv
// Cell writer: segments ingress packets into fixed-size linked cells, writes each
// cell image to buffer memory and emits one descriptor per packet.
module cell_writer #(
  parameter int unsigned BLOCK_BYTES = 64,
  parameter int unsigned NUM_BLOCKS  = 4096,
  parameter int unsigned DATA_WIDTH  = 8,
  localparam int unsigned ADDR_W     = $clog2(NUM_BLOCKS),
  localparam int unsigned CELL_W     = BLOCK_BYTES * 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  alloc_req,
  input  logic                  alloc_gnt,
  input  logic [ADDR_W-1:0]     alloc_idx,
  output logic                  mem_wr_en,
  output logic [ADDR_W-1:0]     mem_wr_addr,
  output logic [CELL_W-1:0]     mem_wr_data,
  output logic                  desc_valid,
  input  logic                  desc_ready,
  output logic [ADDR_W-1:0]     desc_head,
  output logic [15:0]           desc_len,
  output logic [ADDR_W-1:0]     desc_cells
);

  localparam int unsigned PAYLOAD_BYTES = BLOCK_BYTES - 2;
  localparam int unsigned PW            = PAYLOAD_BYTES * DATA_WIDTH;
  localparam int unsigned FW            = CELL_W - PW;
  localparam int unsigned CNT_W         = $clog2(PAYLOAD_BYTES + 1);
  localparam int unsigned OFF_W         = $clog2(PW);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PAYLOAD_BYTES - 1);

  typedef enum logic [2:0] {
    S_ALLOC = 3'd0,
    S_FILL  = 3'd1,
    S_LINK  = 3'd2,
    S_WRITE = 3'd3,
    S_DESC  = 3'd4
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  cur_idx;
  logic [ADDR_W-1:0]  nxt_idx;
  logic [ADDR_W-1:0]  head;
  logic [15:0]        len;
  logic [ADDR_W-1:0]  cells;
  logic [CNT_W-1:0]   cnt;
  logic               eop;
  logic [PW-1:0]      payload;
  logic [PW-1:0]      payload_ins;
  logic [OFF_W-1:0]   bit_off;

  // Current payload with the incoming byte merged in at its slot.
  assign bit_off = OFF_W'(OFF_W'(cnt) * OFF_W'(DATA_WIDTH));

  always_comb begin
    payload_ins = payload;
    payload_ins[bit_off +: DATA_WIDTH] = in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_ALLOC;
      in_ready    <= 1'b0;
      alloc_req   <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      desc_valid  <= 1'b0;
      desc_head   <= '0;
      desc_len    <= '0;
      desc_cells  <= '0;
      cur_idx     <= '0;
      nxt_idx     <= '0;
      head        <= '0;
      len         <= '0;
      cells       <= '0;
      cnt         <= '0;
      eop         <= 1'b0;
      payload     <= '0;
    end else begin
      mem_wr_en <= 1'b0;
      case (state)
        S_ALLOC: begin
          alloc_req <= 1'b1;
          // alloc_req is low only in the first cycle after reset; no grant is taken then.
          if (alloc_req && alloc_gnt) begin
            cur_idx   <= alloc_idx;
            head      <= alloc_idx;
            len       <= '0;
            cells     <= ADDR_W'(1);
            cnt       <= '0;
            payload   <= '0;
            alloc_req <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_FILL;
          end
        end
        S_FILL: begin
          if (in_valid && in_ready) begin
            payload <= payload_ins;
            cnt     <= cnt + CNT_W'(1);
            len     <= len + 16'd1;
            if (in_last) begin
              in_ready    <= 1'b0;
              eop         <= 1'b1;
              mem_wr_en   <= 1'b1;
              mem_wr_addr <= cur_idx;
              mem_wr_data <= {FW'({ADDR_W'(0), 1'b1, 3'b000}), payload_ins};
              state       <= S_WRITE;
            end else if (cnt == LAST_CNT) begin
              in_ready  <= 1'b0;
              alloc_req <= 1'b1;
              state     <= S_LINK;
            end
          end
        end
        S_LINK: begin
          if (alloc_gnt) begin
            nxt_idx     <= alloc_idx;
            cells       <= cells + ADDR_W'(1);
            alloc_req   <= 1'b0;
            eop         <= 1'b0;
            mem_wr_en   <= 1'b1;
            mem_wr_addr <= cur_idx;
            mem_wr_data <= {FW'({alloc_idx, 1'b0, 3'b000}), payload};
            state       <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (eop) begin
            desc_valid <= 1'b1;
            desc_head  <= head;
            desc_len   <= len;
            desc_cells <= cells;
            state      <= S_DESC;
          end else begin
            cur_idx  <= nxt_idx;
            cnt      <= '0;
            payload  <= '0;
            in_ready <= 1'b1;
            state    <= S_FILL;
          end
        end
        S_DESC: begin
          if (desc_ready) begin
            desc_valid <= 1'b0;
            alloc_req  <= 1'b1;
            state      <= S_ALLOC;
          end
        end
        default: state <= S_ALLOC;
      endcase
    end
  end

endmodule

// File: tb/tb_cell_writer.sv
// Randomized scoreboard bench for cell_writer: packets are split into expected
// cell images and descriptors by a reference model, monitor compares as they appear.
module tb_cell_writer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic         alloc_req;
  logic         alloc_gnt;
  logic [11:0]  alloc_idx;
  logic         mem_wr_en;
  logic [11:0]  mem_wr_addr;
  logic [511:0] mem_wr_data;
  logic         desc_valid;
  logic         desc_ready;
  logic [11:0]  desc_head;
  logic [15:0]  desc_len;
  logic [11:0]  desc_cells;

  cell_writer dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .alloc_req  (alloc_req),
    .alloc_gnt  (alloc_gnt),
    .alloc_idx  (alloc_idx),
    .mem_wr_en  (mem_wr_en),
    .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data),
    .desc_valid (desc_valid),
    .desc_ready (desc_ready),
    .desc_head  (desc_head),
    .desc_len   (desc_len),
    .desc_cells (desc_cells)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] idx;
    int          delay;
  } gnt_t;

  typedef struct {
    logic [11:0]  addr;
    logic [511:0] data;
  } wr_t;

  typedef struct {
    logic [11:0] head;
    logic [15:0] len;
    logic [11:0] cells;
    int          rdy_delay;
  } desc_t;

  logic [8:0]  in_q[$];
  gnt_t        gnt_q[$];
  wr_t         wr_q[$];
  desc_t       desc_q[$];
  logic [11:0] fix_idx[$];
  int          fix_del[$];

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int last_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: cut the packet into 62-byte payloads, chain them via the grant list.
  task automatic send_pkt(input int len, input int rdel, input int b0);
    logic [7:0]  b[$];
    logic [11:0] ix[$];
    int          nc;
    gnt_t        g;
    wr_t         w;
    desc_t       d;
    nc = (len + 61) / 62;
    for (int i = 0; i < len; i++) begin
      if (i == 0 && b0 >= 0) b.push_back(8'(b0));
      else b.push_back(8'($urandom));
    end
    for (int k = 0; k < nc; k++) begin
      if (fix_idx.size() > 0) g.idx = fix_idx.pop_front();
      else g.idx = 12'($urandom);
      if (fix_del.size() > 0) g.delay = fix_del.pop_front();
      else if ($urandom_range(0, 7) == 0) g.delay = int'($urandom_range(8, 14));
      else g.delay = int'($urandom_range(0, 2));
      ix.push_back(g.idx);
      gnt_q.push_back(g);
    end
    for (int k = 0; k < nc; k++) begin
      w.addr = ix[k];
      w.data = '0;
      for (int j = 0; j < 62; j++) begin
        if (k * 62 + j < len) w.data[8*j +: 8] = b[k*62+j];
      end
      if (k == nc - 1) w.data[511:496] = 16'h0008;
      else w.data[511:496] = {ix[k+1], 4'h0};
      wr_q.push_back(w);
    end
    for (int i = 0; i < len; i++) in_q.push_back({(i == len - 1), b[i]});
    d.head = ix[0];
    d.len = 16'(len);
    d.cells = 12'(nc);
    d.rdy_delay = rdel;
    desc_q.push_back(d);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 30000 && (in_q.size() + wr_q.size() + desc_q.size()) > 0; i++)
      @(posedge clk);
    repeat (3) @(posedge clk);
    chk("drain_pending", 32'(in_q.size() + wr_q.size() + desc_q.size()), 0);
  endtask

  // Ingress driver
  initial begin
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || in_q.size() == 0 || $urandom_range(0, 4) == 0) begin
        in_valid = 1'b0;
        in_data = 8'($urandom);
        in_last = 1'b0;
      end else begin
        in_valid = 1'b1;
        {in_last, in_data} = in_q[0];
        if (in_ready) begin
          void'(in_q.pop_front());
          acc_cnt++;
          last_acc = cyc;
        end
      end
    end
  end

  // Free-list model with per-grant stall and stray grants while not requested
  initial begin
    int gwait;
    gwait = 0;
    alloc_gnt = 1'b0;
    alloc_idx = '0;
    forever begin
      @(negedge clk);
      alloc_gnt = 1'b0;
      alloc_idx = 12'($urandom);
      if (rst) gwait = 0;
      else if (alloc_req && gnt_q.size() > 0) begin
        if (gwait >= gnt_q[0].delay) begin
          alloc_gnt = 1'b1;
          alloc_idx = gnt_q[0].idx;
          void'(gnt_q.pop_front());
          gwait = 0;
        end else gwait++;
      end else if (!alloc_req && $urandom_range(0, 3) == 0) alloc_gnt = 1'b1;
    end
  end

  // Monitor / descriptor consumer
  initial begin
    int    dwait;
    logic  prev_eop;
    logic  hs_prev;
    wr_t   w;
    desc_t d;
    dwait = 0;
    prev_eop = 1'b0;
    hs_prev = 1'b0;
    desc_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        dwait = 0;
        prev_eop = 1'b0;
        hs_prev = 1'b0;
        desc_ready = 1'b0;
        continue;
      end
      if (hs_prev) chk("alloc_req_after_desc", alloc_req, 1);
      if (prev_eop) chk("desc_latency", desc_valid, 1);
      prev_eop = 1'b0;
      hs_prev = 1'b0;
      if (mem_wr_en) begin
        chk("write_expected", (wr_q.size() > 0), 1);
        if (wr_q.size() > 0) begin
          w = wr_q.pop_front();
          chk("wr_addr", mem_wr_addr, w.addr);
          chk("wr_data", mem_wr_data, w.data);
          if (w.data[499]) begin
            chk("wr_latency", 32'(cyc), 32'(last_acc + 1));
            prev_eop = 1'b1;
          end
        end
      end
      if (alloc_req) begin
        chk("alloc_no_in_ready", in_ready, 0);
        chk("alloc_no_write", mem_wr_en, 0);
      end
      if (desc_valid) begin
        chk("desc_expected", (desc_q.size() > 0), 1);
        desc_ready = 1'b0;
        if (desc_q.size() > 0) begin
          d = desc_q[0];
          chk("desc_head", desc_head, d.head);
          chk("desc_len", desc_len, d.len);
          chk("desc_cells", desc_cells, d.cells);
          chk("desc_in_ready", in_ready, 0);
          chk("desc_alloc_req", alloc_req, 0);
          if (dwait >= d.rdy_delay) begin
            desc_ready = 1'b1;
            void'(desc_q.pop_front());
            dwait = 0;
            hs_prev = 1'b1;
          end else dwait++;
        end
      end else desc_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int lens[10] = '{1, 2, 61, 62, 63, 64, 123, 124, 125, 186};
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_alloc_req", alloc_req, 0);
    chk("rst_mem_wr_en", mem_wr_en, 0);
    chk("rst_desc_valid", desc_valid, 0);
    chk("rst_mem_wr_data", mem_wr_data, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("alloc_req_after_rst", alloc_req, 1);

    // Directed: 1-byte, exact-fit, one-over with a 10-cycle LINK stall and 5-cycle desc stall
    fix_idx = '{12'd5};
    send_pkt(1, 0, 'hAA);
    fix_idx = '{12'd3};
    send_pkt(62, 0, -1);
    fix_idx = '{12'd7, 12'd9};
    fix_del = '{0, 10};
    send_pkt(63, 5, -1);
    wait_drain();

    for (int p = 0; p < 40; p++) begin
      int l;
      if ($urandom_range(0, 1) == 0) l = lens[$urandom_range(0, 9)];
      else l = int'($urandom_range(1, 200));
      send_pkt(l, ($urandom_range(0, 5) == 0) ? 5 : int'($urandom_range(0, 2)), -1);
    end
    wait_drain();

    // Reset after 30 bytes of a 50-byte packet
    acc_cnt = 0;
    send_pkt(50, 0, -1);
    for (int i = 0; i < 2000 && acc_cnt < 30; i++) @(posedge clk);
    chk("mid_pkt_progress", (acc_cnt >= 30), 1);
    #1;
    rst = 1'b1;
    in_q.delete();
    gnt_q.delete();
    wr_q.delete();
    desc_q.delete();
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_alloc_req", alloc_req, 0);
    chk("mid_rst_mem_wr_en", mem_wr_en, 0);
    chk("mid_rst_desc_valid", desc_valid, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    fix_idx = '{12'd100};
    send_pkt(5, 0, -1);
    wait_drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/cell_writer.md
CELL_WRITER -- requirements
Module: cell_writer

Interface
REQ-001 Parameters: BLOCK_BYTES, default 64, cell size in bytes; NUM_BLOCKS, default 4096, cells in buffer memory; DATA_WIDTH, default 8, ingress beat width; ADDR_W = log2(NUM_BLOCKS) = 12; PAYLOAD_BYTES = BLOCK_BYTES-2 = 62.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 in_data  in  8  ingress packet byte; in_valid  in  1  byte present; in_last  in  1  final byte of packet; in_ready  out  1  byte accepted when in_valid&in_ready.
REQ-005 alloc_req  out  1  request a free cell; alloc_gnt  in  1  free list grants this cycle; alloc_idx  in  12  granted cell index, valid with alloc_gnt.
REQ-006 mem_wr_en  out  1  one-cycle cell write strobe; mem_wr_addr  out  12  cell index; mem_wr_data  out  512  full cell image.
REQ-007 desc_valid  out  1  packet descriptor present; desc_ready  in  1  consumer accepts; desc_head  out  12  first cell index; desc_len  out  16  packet bytes; desc_cells  out  12  cells used.

Function
REQ-008 Cell image: payload byte i at mem_wr_data[8i+7:8i], i=0..61; unused payload bytes in a final cell are 0; footer in bits [511:496] = {next_idx[11:0], eop, rsvd[2:0]=0}.
REQ-009 FSM states: ALLOC, FILL, LINK, WRITE, DESC; reset state ALLOC.
REQ-010 ALLOC: alloc_req=1, in_ready=0; on alloc_gnt latch cur_idx=alloc_idx, head=alloc_idx, len=0, cells=1, cnt=0, buffer cleared -> FILL.
REQ-011 FILL: in_ready=1, alloc_req=0; accepted byte stored at buffer[cnt], cnt++, len++ (len wraps mod 2^16).
REQ-012 FILL, accepted byte with in_last=1 (any cnt) -> WRITE with eop=1, next_idx=0.
REQ-013 FILL, accepted byte without in_last at cnt==61 -> LINK; a 62nd byte with in_last goes to WRITE per REQ-012, no extra allocation.
REQ-014 LINK: alloc_req=1, in_ready=0; on alloc_gnt latch nxt_idx=alloc_idx, cells++ -> WRITE with eop=0, next_idx=nxt_idx; alloc_gnt outside ALLOC/LINK ignored.
REQ-015 WRITE: mem_wr_en=1 exactly one cycle, mem_wr_addr=cur_idx, in_ready=0; if eop -> DESC, else cur_idx=nxt_idx, cnt=0, buffer cleared -> FILL.
REQ-016 DESC: desc_valid=1, in_ready=0, desc_head/len/cells stable until desc_valid&desc_ready -> ALLOC.
REQ-017 Latency: last byte accepted cycle N -> mem_wr_en cycle N+1 -> desc_valid cycle N+2.
REQ-018 Free-list stall: alloc_gnt may be withheld indefinitely; block waits in ALLOC/LINK with alloc_req held and no input accepted.
REQ-019 No packet drop; zero-length packets do not exist (every packet has >=1 byte).
REQ-020 mem_wr_data, desc_* outputs registered; no combinational path in_valid->in_ready.

Reset
REQ-021 On rst: state=ALLOC, in_ready=0, alloc_req=0 in reset then 1 from first cycle after release, mem_wr_en=0, desc_valid=0, all counters, indices, buffer = 0.
REQ-022 Reset mid-packet abandons the packet; cells already allocated are not returned (recovered by system-level free-list reinit); no write or descriptor issued for it.

Verification
REQ-023 1-byte packet 0xAA, alloc_idx=5 -> write addr 5, byte0=0xAA, bytes1..61=0, bits[511:496]=16'h0008; desc head=5 len=1 cells=1.
REQ-024 62-byte packet, alloc_idx=3 -> single write addr 3, footer 16'h0008, alloc_req not asserted in LINK; desc len=62 cells=1.
REQ-025 63-byte packet, grants 7 then 9 -> write addr 7 footer 16'h0090 (next=9, eop=0), then addr 9 byte0=63rd byte, footer 16'h0008; desc head=7 len=63 cells=2.
REQ-026 LINK with alloc_gnt withheld 10 cycles -> alloc_req high, in_ready low, no mem_wr_en for 10 cycles; resumes correctly on grant.
REQ-027 desc_ready low 5 cycles -> desc_* stable, in_ready=0, no alloc_req; after handshake alloc_req asserts next cycle.
REQ-028 rst asserted after 30 bytes of a packet -> outputs per REQ-021 immediately; next packet starts at ALLOC with fresh head, no stale bytes in its first cell.
